// File: rtl/ram_arbiter_if.sv
// Bundle of the CPU, loader and RAM-side signals of the two-port RAM arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives the ports.
interface ram_arbiter_if;
    logic       cpu_req;
    logic       cpu_rw;
    logic [7:0] cpu_addr;
    logic [3:0] cpu_wdata;
    logic       cpu_ack;
    logic [3:0] cpu_rdata;

    logic       ldr_req;
    logic       ldr_rw;
    logic [7:0] ldr_addr;
    logic [3:0] ldr_wdata;
    logic       ldr_ack;
    logic [3:0] ldr_rdata;

    logic       ram_EN;
    logic       ram_RW;
    logic [7:0] ram_address_bus;
    logic [3:0] ram_data_bus_out;
    logic [3:0] ram_data_bus_in;
    logic [1:0] grant;
    logic       busy;

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_rw, ldr_addr, ldr_wdata,
        input  ram_data_bus_in,
        output cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
        output ram_EN, ram_RW, ram_address_bus, ram_data_bus_out,
        output grant, busy
    );

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        output ldr_req, ldr_rw, ldr_addr, ldr_wdata,
        output ram_data_bus_in,
        input  cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
        input  ram_EN, ram_RW, ram_address_bus, ram_data_bus_out,
        input  grant, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a CPU and a loader port.
// Every output comes straight from a flop; one access takes RD_LAT+2 cycles.
//
//   state  | meaning
//   IDLE   | no transaction; arbitrate on the next edge
//   ACCESS | ram_EN high for RD_LAT cycles with the winner's latched request
//   DONE   | one cycle, winner's ack high, grant still held
module ram_arbiter #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_grant_q, last_grant_d;
    logic       en_q, en_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [3:0] wdata_q, wdata_d;
    logic [1:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       cpu_ack_q, cpu_ack_d;
    logic       ldr_ack_q, ldr_ack_d;
    logic [3:0] cpu_rdata_q, cpu_rdata_d;
    logic [3:0] ldr_rdata_q, ldr_rdata_d;
    logic       pick_ldr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            en_q         <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            cpu_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            en_q         <= en_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            cpu_ack_q    <= cpu_ack_d;
            ldr_ack_q    <= ldr_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        en_d         = en_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        cpu_ack_d    = 1'b0;
        ldr_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        // On a tie the loader wins only if the CPU was served last.
        pick_ldr     = bus.ldr_req && (!bus.cpu_req || !last_grant_q);

        case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.ldr_req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    grant_d = pick_ldr ? 2'b10 : 2'b01;
                    rw_d    = pick_ldr ? bus.ldr_rw    : bus.cpu_rw;
                    addr_d  = pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
                    wdata_d = pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d   = DONE;
                    en_d      = 1'b0;
                    rw_d      = 1'b0;
                    cpu_ack_d = grant_q[0];
                    ldr_ack_d = grant_q[1];
                    // rw_q still carries the latched direction on this edge.
                    if (!rw_q) begin
                        if (grant_q[1]) ldr_rdata_d = bus.ram_data_bus_in;
                        else            cpu_rdata_d = bus.ram_data_bus_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d      = IDLE;
                grant_d      = 2'b00;
                busy_d       = 1'b0;
                last_grant_d = grant_q[1];
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ram_EN           = en_q;
    assign bus.ram_RW           = rw_q;
    assign bus.ram_address_bus  = addr_q;
    assign bus.ram_data_bus_out = wdata_q;
    assign bus.grant            = grant_q;
    assign bus.busy             = busy_q;
    assign bus.cpu_ack          = cpu_ack_q;
    assign bus.ldr_ack          = ldr_ack_q;
    assign bus.cpu_rdata        = cpu_rdata_q;
    assign bus.ldr_rdata        = ldr_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Random two-port traffic into arbiters with RD_LAT 1 and 3, each checked every cycle
// against a transaction-phase model; includes a tie storm after reset and an async reset mid-access.
module tb_ram_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    ram_arbiter_if bus0();
    ram_arbiter_if bus1();

    ram_arbiter #(.RD_LAT(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    ram_arbiter #(.RD_LAT(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // model: phase 0 idle, 1..lat access cycle index, lat+1 ack cycle
    int         lat   [2];
    int         phase [2];
    int         owner [2];
    int         last  [2];
    logic       t_rw  [2];
    logic [7:0] h_addr[2];
    logic [3:0] h_data[2];
    logic [3:0] m_rdata[2][2];

    logic       req [2][2];
    logic       rw  [2][2];
    logic [7:0] addr[2][2];
    logic [3:0] wd  [2][2];
    logic [3:0] rin [2];

    logic       o_en[2], o_rw[2], o_cack[2], o_lack[2], o_busy[2];
    logic [7:0] o_addr[2];
    logic [3:0] o_dout[2], o_crd[2], o_lrd[2];
    logic [1:0] o_grant[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sample();
        o_en[0] = bus0.ram_EN;           o_en[1] = bus1.ram_EN;
        o_rw[0] = bus0.ram_RW;           o_rw[1] = bus1.ram_RW;
        o_addr[0] = bus0.ram_address_bus; o_addr[1] = bus1.ram_address_bus;
        o_dout[0] = bus0.ram_data_bus_out; o_dout[1] = bus1.ram_data_bus_out;
        o_grant[0] = bus0.grant;         o_grant[1] = bus1.grant;
        o_busy[0] = bus0.busy;           o_busy[1] = bus1.busy;
        o_cack[0] = bus0.cpu_ack;        o_cack[1] = bus1.cpu_ack;
        o_lack[0] = bus0.ldr_ack;        o_lack[1] = bus1.ldr_ack;
        o_crd[0] = bus0.cpu_rdata;       o_crd[1] = bus1.cpu_rdata;
        o_lrd[0] = bus0.ldr_rdata;       o_lrd[1] = bus1.ldr_rdata;
    endtask

    task automatic apply();
        bus0.cpu_req = req[0][0]; bus0.cpu_rw = rw[0][0]; bus0.cpu_addr = addr[0][0]; bus0.cpu_wdata = wd[0][0];
        bus0.ldr_req = req[0][1]; bus0.ldr_rw = rw[0][1]; bus0.ldr_addr = addr[0][1]; bus0.ldr_wdata = wd[0][1];
        bus0.ram_data_bus_in = rin[0];
        bus1.cpu_req = req[1][0]; bus1.cpu_rw = rw[1][0]; bus1.cpu_addr = addr[1][0]; bus1.cpu_wdata = wd[1][0];
        bus1.ldr_req = req[1][1]; bus1.ldr_rw = rw[1][1]; bus1.ldr_addr = addr[1][1]; bus1.ldr_wdata = wd[1][1];
        bus1.ram_data_bus_in = rin[1];
    endtask

    task automatic model_reset(input int d);
        phase[d]  = 0;
        owner[d]  = 0;
        last[d]   = 1;
        t_rw[d]   = 1'b0;
        h_addr[d] = '0;
        h_data[d] = '0;
        m_rdata[d][0] = '0;
        m_rdata[d][1] = '0;
    endtask

    task automatic check_dut(input int d);
        string s;
        logic  en;
        s  = $sformatf("rdlat%0d", lat[d]);
        en = (phase[d] >= 1) && (phase[d] <= lat[d]);
        chk({s, ".ram_EN"},    32'(o_en[d]),    32'(en));
        chk({s, ".ram_RW"},    32'(o_rw[d]),    32'(en && t_rw[d]));
        chk({s, ".ram_addr"},  32'(o_addr[d]),  32'(h_addr[d]));
        chk({s, ".ram_dout"},  32'(o_dout[d]),  32'(h_data[d]));
        chk({s, ".grant"},     32'(o_grant[d]), (phase[d] == 0) ? 32'd0 : ((owner[d] == 1) ? 32'd2 : 32'd1));
        chk({s, ".busy"},      32'(o_busy[d]),  32'(phase[d] != 0));
        chk({s, ".cpu_ack"},   32'(o_cack[d]),  32'(phase[d] == lat[d] + 1 && owner[d] == 0));
        chk({s, ".ldr_ack"},   32'(o_lack[d]),  32'(phase[d] == lat[d] + 1 && owner[d] == 1));
        chk({s, ".cpu_rdata"}, 32'(o_crd[d]),   32'(m_rdata[d][0]));
        chk({s, ".ldr_rdata"}, 32'(o_lrd[d]),   32'(m_rdata[d][1]));
    endtask

    task automatic pick_inputs(input int d, input bit storm);
        for (int p = 0; p < 2; p++) begin
            bit mine;
            mine = (phase[d] != 0) && (owner[d] == p);
            if (phase[d] == lat[d] + 1 && owner[d] == p)
                req[d][p] = 1'b0;
            else if (!req[d][p]) begin
                if (!mine && (storm || $urandom_range(2) == 0)) req[d][p] = 1'b1;
            end else if (mine && !storm && phase[d] <= lat[d] && $urandom_range(5) == 0)
                req[d][p] = 1'b0;
            rw[d][p]   = 1'($urandom_range(1));
            addr[d][p] = 8'($urandom_range(255));
            wd[d][p]   = 4'($urandom_range(15));
        end
        rin[d] = 4'($urandom_range(15));
    endtask

    // advance the model across the coming rising edge using the inputs just applied
    task automatic model_edge(input int d);
        if (phase[d] == 0) begin
            if (req[d][0] || req[d][1]) begin
                if (req[d][0] && req[d][1]) owner[d] = 1 - last[d];
                else                        owner[d] = req[d][0] ? 0 : 1;
                t_rw[d]   = rw[d][owner[d]];
                h_addr[d] = addr[d][owner[d]];
                h_data[d] = wd[d][owner[d]];
                phase[d]  = 1;
            end
        end else if (phase[d] <= lat[d]) begin
            if (phase[d] == lat[d] && !t_rw[d]) m_rdata[d][owner[d]] = rin[d];
            phase[d]++;
        end else begin
            last[d]  = owner[d];
            phase[d] = 0;
        end
    endtask

    initial begin
        bit rst_done;
        int storm_until;
        lat[0] = 1;
        lat[1] = 3;
        rst_n = 1'b0;
        rst_done = 1'b0;
        storm_until = 40;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            rin[d] = '0;
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; rw[d][p] = 1'b0; addr[d][p] = '0; wd[d][p] = '0;
            end
        end
        apply();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            sample();
            check_dut(0);
            check_dut(1);
            if (!rst_done && cyc >= 1500 && phase[1] == 2) begin
                rst_n = 1'b0;
                #1;
                sample();
                model_reset(0);
                model_reset(1);
                check_dut(0);
                check_dut(1);
                for (int d = 0; d < 2; d++) begin
                    req[d][0] = 1'b1;
                    req[d][1] = 1'b1;
                end
                apply();
                rst_done = 1'b1;
                storm_until = cyc + 40;
            end else begin
                rst_n = 1'b1;
                pick_inputs(0, cyc < storm_until);
                pick_inputs(1, cyc < storm_until);
                apply();
                model_edge(0);
                model_edge(1);
            end
        end

        if (!rst_done) chk("reset_mid_access_reached", 32'd0, 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
